// File: rtl/demux_1_to_4_stream.sv
// Packet-aware 1-to-4 stream demux with a one-entry output register per channel.
// Define DEMUX_BEAT_CNT_EN to add per-channel 16-bit transfer counters on beat_cnt_o.
module demux_1_to_4_stream #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            select_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic [DATA_WIDTH-1:0] data3_o,
  output logic                  last0_o,
  output logic                  last1_o,
  output logic                  last2_o,
  output logic                  last3_o,
  output logic                  valid0_o,
  output logic                  valid1_o,
  output logic                  valid2_o,
  output logic                  valid3_o,
`ifdef DEMUX_BEAT_CNT_EN
  output logic [63:0]           beat_cnt_o,
`endif
  input  logic                  ready0_i,
  input  logic                  ready1_i,
  input  logic                  ready2_i,
  input  logic                  ready3_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [1:0] sel_q, sel_next;
  logic [1:0] target;
  logic       accept;

  logic [3:0]            ch_ready;
  logic [3:0]            ch_valid;
  logic [3:0]            ch_last;
  logic [DATA_WIDTH-1:0] ch_data [4];

  assign ch_ready = {ready3_i, ready2_i, ready1_i, ready0_i};

  // The destination is only taken from select_i on the first beat of a packet.
  assign target  = (state_reg == IDLE) ? select_i : sel_q;
  assign ready_o = ~ch_valid[target] | ch_ready[target];
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      sel_q     <= 2'd0;
    end else begin
      state_reg <= state_next;
      sel_q     <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_q;
    case (state_reg)
      IDLE: begin
        if (accept && !last_i) begin
          state_next = LOCKED;
          sel_next   = select_i;
        end
      end
      LOCKED: begin
        if (accept && last_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic                  load;
      logic                  xfer;
      logic                  valid_reg;
      logic                  last_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      assign load = accept && (target == 2'(gi));
      assign xfer = valid_reg & ch_ready[gi];

      // A load wins over a drain so back-to-back beats keep valid high.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          data_reg  <= '0;
        end else if (load) begin
          valid_reg <= 1'b1;
          last_reg  <= last_i;
          data_reg  <= data_i;
        end else if (xfer) begin
          valid_reg <= 1'b0;
        end
      end

      assign ch_valid[gi] = valid_reg;
      assign ch_last[gi]  = last_reg;
      assign ch_data[gi]  = data_reg;

`ifdef DEMUX_BEAT_CNT_EN
      logic [15:0] cnt_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg <= 16'd0;
        end else if (xfer) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign beat_cnt_o[16*gi +: 16] = cnt_reg;
`endif
    end
  endgenerate

  assign data0_o  = ch_data[0];
  assign data1_o  = ch_data[1];
  assign data2_o  = ch_data[2];
  assign data3_o  = ch_data[3];
  assign last0_o  = ch_last[0];
  assign last1_o  = ch_last[1];
  assign last2_o  = ch_last[2];
  assign last3_o  = ch_last[3];
  assign valid0_o = ch_valid[0];
  assign valid1_o = ch_valid[1];
  assign valid2_o = ch_valid[2];
  assign valid3_o = ch_valid[3];

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Directed bench for demux_1_to_4_stream: inputs change on the falling edge,
// registered outputs are checked on the falling edge after each rising edge.
module tb_demux_1_to_4_stream;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [1:0]  select_i;
  logic        last_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o, data1_o, data2_o, data3_o;
  logic        last0_o, last1_o, last2_o, last3_o;
  logic        valid0_o, valid1_o, valid2_o, valid3_o;
  logic        ready0_i, ready1_i, ready2_i, ready3_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  demux_1_to_4_stream #(.DATA_WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .last_i   (last_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .data2_o  (data2_o),
    .data3_o  (data3_o),
    .last0_o  (last0_o),
    .last1_o  (last1_o),
    .last2_o  (last2_o),
    .last3_o  (last3_o),
    .valid0_o (valid0_o),
    .valid1_o (valid1_o),
    .valid2_o (valid2_o),
    .valid3_o (valid3_o),
    .ready0_i (ready0_i),
    .ready1_i (ready1_i),
    .ready2_i (ready2_i),
    .ready3_i (ready3_i)
  );

  wire [3:0] valids = {valid3_o, valid2_o, valid1_o, valid0_o};
  wire [3:0] lasts  = {last3_o, last2_o, last1_o, last0_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic l);
    valid_i  = v;
    select_i = s;
    data_i   = d;
    last_i   = l;
    if (v) $display("beat sel=%0d data=%h last=%0d t=%0t", s, d, l, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    {ready3_i, ready2_i, ready1_i, ready0_i} = 4'b1111;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_valids", valids, 4'b0000);
    check("rst_lasts", lasts, 4'b0000);
    check("rst_data0", data0_o, 32'h0);
    check("rst_data3", data3_o, 32'h0);
    check("rst_ready", ready_o, 1'b1);

    // Single-beat packet to channel 2
    drive(1'b1, 2'd2, 32'hA5A5A5A5, 1'b1);
    #1 check("single_ready", ready_o, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    check("single_valids", valids, 4'b0100);
    check("single_data2", data2_o, 32'hA5A5A5A5);
    check("single_last2", last2_o, 1'b1);
    step();
    check("single_drained", valids, 4'b0000);
    check("single_data_hold", data2_o, 32'hA5A5A5A5);

    // Packet lock: select changes mid-packet are ignored
    drive(1'b1, 2'd1, 32'h11, 1'b0);
    step();
    check("lock_b1_valids", valids, 4'b0010);
    check("lock_b1_data", data1_o, 32'h11);
    check("lock_b1_last", last1_o, 1'b0);
    drive(1'b1, 2'd3, 32'h22, 1'b0);
    step();
    check("lock_b2_valids", valids, 4'b0010);
    check("lock_b2_data", data1_o, 32'h22);
    check("lock_b2_last", last1_o, 1'b0);
    drive(1'b1, 2'd3, 32'h33, 1'b1);
    step();
    check("lock_b3_valids", valids, 4'b0010);
    check("lock_b3_data", data1_o, 32'h33);
    check("lock_b3_last", last1_o, 1'b1);
    // FSM should be back in IDLE so select 3 routes to channel 3
    drive(1'b1, 2'd3, 32'h44, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    check("unlock_valids", valids, 4'b1000);
    check("unlock_data3", data3_o, 32'h44);
    step();

    // Backpressure on channel 0
    ready0_i = 1'b0;
    drive(1'b1, 2'd0, 32'h100, 1'b0);
    #1 check("bp_ready_empty", ready_o, 1'b1);
    step();
    drive(1'b1, 2'd2, 32'h101, 1'b0);
    #1 check("bp_ready_full", ready_o, 1'b0);
    step();
    check("bp_data_stable", data0_o, 32'h100);
    check("bp_valid_held", valids, 4'b0001);
    ready0_i = 1'b1;
    #1 check("bp_ready_pass", ready_o, 1'b1);
    step();
    check("bp_reload_data", data0_o, 32'h101);
    check("bp_reload_valid", valids, 4'b0001);
    drive(1'b1, 2'd1, 32'h102, 1'b1);
    #1 check("bp_ready_b2b", ready_o, 1'b1);
    step();
    check("bp_b2b_data", data0_o, 32'h102);
    check("bp_b2b_last", last0_o, 1'b1);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    step();
    check("bp_drained", valids, 4'b0000);

    // Independent drain: channel 1 stalled while channel 3 streams
    ready1_i = 1'b0;
    drive(1'b1, 2'd1, 32'h200, 1'b1);
    step();
    drive(1'b1, 2'd3, 32'h300, 1'b0);
    #1 check("ind_ready", ready_o, 1'b1);
    step();
    check("ind_b1_valids", valids, 4'b1010);
    check("ind_b1_data3", data3_o, 32'h300);
    drive(1'b1, 2'd1, 32'h301, 1'b1);
    #1 check("ind_ready2", ready_o, 1'b1);
    step();
    check("ind_b2_data3", data3_o, 32'h301);
    check("ind_b2_last3", last3_o, 1'b1);
    check("ind_data1_hold", data1_o, 32'h200);
    check("ind_b2_valids", valids, 4'b1010);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    ready1_i = 1'b1;
    step();
    check("ind_drained", valids, 4'b0000);

    // Reset mid-packet
    drive(1'b1, 2'd0, 32'h400, 1'b0);
    step();
    drive(1'b1, 2'd2, 32'h401, 1'b0);
    step();
    ready0_i = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    check("mid_before_rst", valids, 4'b0001);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ready0_i = 1'b1;
    check("mid_rst_valids", valids, 4'b0000);
    check("mid_rst_data0", data0_o, 32'h0);
    check("mid_rst_lasts", lasts, 4'b0000);
    #1 check("mid_rst_ready", ready_o, 1'b1);
    drive(1'b1, 2'd3, 32'h500, 1'b0);
    step();
    check("mid_new_valids", valids, 4'b1000);
    check("mid_new_data3", data3_o, 32'h500);
    drive(1'b1, 2'd0, 32'h501, 1'b1);
    step();
    check("mid_tail_data3", data3_o, 32'h501);
    check("mid_tail_valids", valids, 4'b1000);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    step();
    check("final_drained", valids, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
